mips32_program_loader: RTL and testbench
========================================

# mips32_program_loader

Byte-stream program loader that writes instruction and data words into the Pipelined_MIPS32 unified memory (`MEM`) before execution.

- Parses a framed byte stream: sync byte, start address, word count, big-endian words, XOR checksum.
- Each completed word is presented as a one-cycle write on the memory write port.
- Holds the processor (`cpu_hold`) until a frame has loaded and its checksum has passed.

## Interface
Parameters:
- `ADDR_W`, 9 — memory address width.
- `MEM_DEPTH`, 501 — number of 32-bit words in `MEM`. The highest legal word address is `MEM_DEPTH-1`.
- `SYNC`, 8'hA5 — frame start byte.

Ports:
- `clk1`  in  1 — single clock; all state changes on the rising edge.
- `rst_n`  in  1 — reset, synchronous, active-low.
- `in_valid`  in  1 — byte-stream valid.
- `in_data`  in  8 — byte-stream data.
- `in_ready`  out  1 — loader can accept a byte this cycle.
- `mem_we`  out  1 — one-cycle memory write strobe.
- `mem_addr`  out  ADDR_W — write word address.
- `mem_wdata`  out  32 — write data.
- `cpu_hold`  out  1 — hold the processor (drives its clock gating / HALTED).
- `done`  out  1 — sticky; last frame loaded and checksum OK.
- `err`  out  1 — sticky; last frame rejected.
- `words_loaded`  out  16 — words written in the current or last frame.

## Operation
- **Accepting a byte:** a byte is accepted on a rising edge when `in_valid && in_ready`.
- **Frame format:** `SYNC`, `ADDR_HI`, `ADDR_LO`, `CNT_HI`, `CNT_LO`, then `CNT`×4 data bytes (MSB first), then `CHK`.
  - `CHK` = XOR of every byte after `SYNC`, up to and including the last data byte.
- **States:** `IDLE` → `A_HI` → `A_LO` → `C_HI` → `C_LO` → `DATA` → `CHK`, then back to `IDLE`.
- **`IDLE`:**
  - Non-`SYNC` bytes are discarded with no effect.
  - `SYNC` clears `done`, `err`, `words_loaded`, the checksum accumulator and the byte counter; next state `A_HI`.
- **Header states:** `A_HI`/`A_LO`/`C_HI`/`C_LO` latch the 16-bit start address `ADDR` and the 16-bit count `CNT`, and accumulate into the checksum.
- **Range check, on accepting `CNT_LO`:**
  - Compute `ADDR + CNT` in 17 bits.
  - If it exceeds `MEM_DEPTH`: `err`=1, next state `IDLE`, no writes.
  - Else if `CNT==0`: next state `CHK`.
  - Else: next state `DATA`.
- **`DATA`:**
  - Bytes shift into a 32-bit assembler, MSB first, with a 2-bit byte counter.
  - On the 4th byte, the next cycle drives `mem_we`=1, `mem_addr`=`ADDR[ADDR_W-1:0]`+`words_loaded`, `mem_wdata`=the assembled word; `words_loaded` increments in that same cycle.
  - After word `CNT` is written, next state `CHK`.
- **`CHK`:**
  - Accepted byte equals the accumulator: `done`=1.
  - Otherwise: `err`=1.
  - Either way, next state `IDLE`.
  - Words already written on a failed checksum are not rolled back.
- **`cpu_hold`:** 1 out of reset and throughout any frame; 0 only while `done`=1. A new `SYNC` re-asserts it in the cycle after acceptance.
- **Truncation:** no timeout; a truncated frame waits indefinitely, and only `rst_n` recovers it.

## Timing
- **Reset values:**
  - `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_hold`=1, `done`=0, `err`=0, `words_loaded`=0.
  - State `IDLE`; assembler, counters and accumulator cleared.
- **Write latency:** the 4th data byte is accepted at edge N; `mem_we`=1 for cycle N..N+1 only; the write commits at edge N+1.
- **Back-pressure:** `in_ready`=0 exactly in each cycle where `mem_we`=1, and is 1 in every other cycle. So with `in_valid` held high, one frame word takes 5 cycles.
- **Flag timing:** `done`/`err` rise in the cycle after the deciding byte (`CHK` or `CNT_LO`) is accepted. `cpu_hold` falls in the same cycle as `done` rises.
- **Other outputs:** `mem_addr`/`mem_wdata` hold their last value when `mem_we`=0.
- **Reset mid-frame:** `rst_n`=0 at any edge discards the partial word and header. No `mem_we` is issued after that edge; all outputs take their reset values at that edge.
- **Address wrap:** does not occur; the range check forbids `ADDR+CNT` > `MEM_DEPTH`. `ADDR+CNT` == `MEM_DEPTH` is legal, and the last write goes to `MEM_DEPTH-1`.

## Test plan
- **Good frame:** stream A5 00 10 00 02 20 01 00 05 FC 00 00 00 CA with `in_valid` held high.
  - Writes 0x20010005 @ 0x010 and 0xFC000000 @ 0x011, each a 1-cycle `mem_we`, with `in_ready` low in those cycles.
  - Then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- **Bad checksum:** same frame with last byte CB.
  - Both writes still occur.
  - `err`=1, `done`=0, `cpu_hold` stays 1.
  - Then send the good frame: `done`=1, `err`=0.
- **Range error:** A5 01 F0 00 06 (496+6 > 501).
  - `err`=1 one cycle after `CNT_LO`; zero `mem_we` pulses.
  - A following data byte is ignored (`IDLE`).
- **Edge of memory and empty frame:**
  - A5 01 F4 00 01 + word 11223344 + correct `CHK`: writes @500, `done`=1.
  - A5 00 00 00 00 00: `done`=1, no writes.
- **Sync hunt and throttling:**
  - 00 FF 5A before a good frame: ignored, no effect.
  - Random `in_valid` gaps within a frame: the same writes are produced.
- **Reset mid-frame:** `rst_n` low for 1 cycle after 2 data bytes.
  - All outputs return to reset values; no `mem_we`.
  - The next good frame loads normally.

Source files
------------

// File: rtl/mips32_program_loader.sv
// Framed byte-stream loader: SYNC, 16-bit addr, 16-bit count, big-endian words, XOR check.
// Each assembled word is a one-cycle write; in_ready drops only in that write cycle.
module mips32_program_loader #(
  parameter int          ADDR_W    = 9,
  parameter int          MEM_DEPTH = 501,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_A_HI = 3'd1;
  localparam logic [2:0] S_A_LO = 3'd2;
  localparam logic [2:0] S_C_HI = 3'd3;
  localparam logic [2:0] S_C_LO = 3'd4;
  localparam logic [2:0] S_DATA = 3'd5;
  localparam logic [2:0] S_CHK  = 3'd6;

  localparam logic [16:0] DEPTH17 = 17'(MEM_DEPTH);

  logic [2:0]  state;
  logic [15:0] addr;
  logic [15:0] cnt;
  logic [7:0]  acc;
  logic [31:0] shreg;
  logic [1:0]  bcnt;
  logic        accept;
  logic [15:0] cnt_full;
  logic [16:0] range_sum;

  // The only cycle the loader stalls is the write cycle itself.
  assign in_ready  = ~mem_we;
  assign accept    = in_valid & in_ready;
  assign cpu_hold  = ~done;
  assign cnt_full  = {cnt[15:8], in_data};
  assign range_sum = {1'b0, addr} + {1'b0, cnt_full};

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr         <= '0;
      cnt          <= '0;
      acc          <= '0;
      shreg        <= '0;
      bcnt         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (in_data == SYNC) begin
              done         <= 1'b0;
              err          <= 1'b0;
              words_loaded <= '0;
              acc          <= '0;
              bcnt         <= '0;
              state        <= S_A_HI;
            end
          end
          S_A_HI: begin
            addr[15:8] <= in_data;
            acc        <= acc ^ in_data;
            state      <= S_A_LO;
          end
          S_A_LO: begin
            addr[7:0] <= in_data;
            acc       <= acc ^ in_data;
            state     <= S_C_HI;
          end
          S_C_HI: begin
            cnt[15:8] <= in_data;
            acc       <= acc ^ in_data;
            state     <= S_C_LO;
          end
          S_C_LO: begin
            cnt[7:0] <= in_data;
            acc      <= acc ^ in_data;
            if (range_sum > DEPTH17) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else if (cnt_full == 16'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            shreg <= {shreg[23:0], in_data};
            acc   <= acc ^ in_data;
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= addr[ADDR_W-1:0] + words_loaded[ADDR_W-1:0];
              mem_wdata    <= {shreg[23:0], in_data};
              words_loaded <= words_loaded + 16'd1;
              if (words_loaded + 16'd1 == cnt) state <= S_CHK;
            end
          end
          S_CHK: begin
            if (in_data == acc) done <= 1'b1;
            else                err  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips32_program_loader.sv
// Directed bench for mips32_program_loader; writes captured by a negedge monitor.
module tb_mips32_program_loader;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [8:0]  wq_a[$];
  logic [31:0] wq_d[$];
  logic [7:0]  fr[$];

  mips32_program_loader #(.ADDR_W(9), .MEM_DEPTH(501), .SYNC(8'hA5)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Capture writes and enforce in_ready low exactly during write cycles.
  always @(negedge clk1) begin
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        wq_a.push_back(mem_addr);
        wq_d.push_back(mem_wdata);
      end
      chk("ready_vs_we", {31'd0, in_ready}, {31'd0, ~mem_we});
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk1);
        in_valid = 1'b0;
      end
    end
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk1);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk1);
  endtask

  task automatic send_frame(input bit gaps);
    foreach (fr[i]) send_byte(fr[i], gaps);
  endtask

  task automatic step();
    @(negedge clk1);
    in_valid = 1'b0;
  endtask

  task automatic clear_writes();
    wq_a.delete();
    wq_d.delete();
  endtask

  task automatic good_frame(input logic [7:0] last);
    fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
           8'hFC, 8'h00, 8'h00, 8'h00, 8'hCA};
    fr[13] = last;
  endtask

  task automatic check_good_writes(input string tag);
    chk({tag, "_nwr"}, wq_a.size(), 32'd2);
    if (wq_a.size() == 2) begin
      chk({tag, "_a0"}, {23'd0, wq_a[0]}, 32'h010);
      chk({tag, "_d0"}, wq_d[0], 32'h20010005);
      chk({tag, "_a1"}, {23'd0, wq_a[1]}, 32'h011);
      chk({tag, "_d1"}, wq_d[1], 32'hFC000000);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_we"},    {31'd0, mem_we},   32'd0);
    chk({tag, "_addr"},  {23'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata,         32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, done},     32'd0);
    chk({tag, "_err"},   {31'd0, err},      32'd0);
    chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk1);
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Good frame, in_valid held high
    clear_writes();
    good_frame(8'hCA);
    send_frame(1'b0);
    step();
    chk("good_done", {31'd0, done}, 32'd1);
    chk("good_err", {31'd0, err}, 32'd0);
    chk("good_hold", {31'd0, cpu_hold}, 32'd0);
    chk("good_words", {16'd0, words_loaded}, 32'd2);
    check_good_writes("good");

    // Bad checksum: writes still happen, err raised
    clear_writes();
    good_frame(8'hCB);
    send_frame(1'b0);
    step();
    chk("badchk_err", {31'd0, err}, 32'd1);
    chk("badchk_done", {31'd0, done}, 32'd0);
    chk("badchk_hold", {31'd0, cpu_hold}, 32'd1);
    check_good_writes("badchk");

    clear_writes();
    good_frame(8'hCA);
    send_frame(1'b0);
    step();
    chk("recover_done", {31'd0, done}, 32'd1);
    chk("recover_err", {31'd0, err}, 32'd0);

    // Range error: 0x1F0 + 6 exceeds 501
    clear_writes();
    fr = '{8'hA5, 8'h01, 8'hF0, 8'h00, 8'h06};
    send_frame(1'b0);
    step();
    chk("range_err", {31'd0, err}, 32'd1);
    chk("range_done", {31'd0, done}, 32'd0);
    chk("range_hold", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h20, 1'b0);
    repeat (3) step();
    chk("range_nwr", wq_a.size(), 32'd0);
    chk("range_words", {16'd0, words_loaded}, 32'd0);
    chk("range_err_sticky", {31'd0, err}, 32'd1);

    // Last legal word address 500
    clear_writes();
    fr = '{8'hA5, 8'h01, 8'hF4, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hB0};
    send_frame(1'b0);
    step();
    chk("edge_done", {31'd0, done}, 32'd1);
    chk("edge_nwr", wq_a.size(), 32'd1);
    if (wq_a.size() == 1) begin
      chk("edge_addr", {23'd0, wq_a[0]}, 32'd500);
      chk("edge_data", wq_d[0], 32'h11223344);
    end

    // Empty frame
    clear_writes();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    step();
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_words", {16'd0, words_loaded}, 32'd0);
    chk("empty_nwr", wq_a.size(), 32'd0);

    // Sync hunt: noise bytes leave the previous result untouched
    clear_writes();
    fr = '{8'h00, 8'hFF, 8'h5A};
    send_frame(1'b0);
    step();
    chk("hunt_done", {31'd0, done}, 32'd1);
    chk("hunt_hold", {31'd0, cpu_hold}, 32'd0);
    chk("hunt_nwr", wq_a.size(), 32'd0);

    // Throttled good frame
    good_frame(8'hCA);
    send_frame(1'b1);
    step();
    chk("gaps_done", {31'd0, done}, 32'd1);
    chk("gaps_words", {16'd0, words_loaded}, 32'd2);
    check_good_writes("gaps");

    // Reset after two data bytes
    clear_writes();
    fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h20, 8'h01};
    send_frame(1'b0);
    chk("mid_hold", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk1);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    repeat (5) step();
    chk("midrst_nwr", wq_a.size(), 32'd0);

    clear_writes();
    good_frame(8'hCA);
    send_frame(1'b0);
    step();
    chk("after_rst_done", {31'd0, done}, 32'd1);
    check_good_writes("after_rst");

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
